// File: rtl/uart_mmio_pkg.sv
// +----------------------------------------------------------------------+
// | uart_mmio_pkg                                                         |
// | Shared register offsets, STATUS layout and TX FSM states.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_mmio_pkg;

  localparam logic [13:0] OFS_TXDATA  = 14'd0;
  localparam logic [13:0] OFS_STATUS  = 14'd1;
  localparam logic [13:0] OFS_BAUDDIV = 14'd2;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_COUNT  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +----------------------------------------------------------------------+
// | uart_tx_fifo                                                          |
// | Synchronous show-ahead FIFO feeding the UART shifter.                 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// +----------------------------------------------------------------------+
// | uart_tx_mmio                                                          |
// | Memory-mapped 8N1 UART transmitter on the CPU data-memory bus.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [13:0] BASE_WADDR = 14'h3FF0,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [13:0] w_addr,
  input  logic [31:0] w_data,
  input  logic [13:0] r_addr,
  output logic [31:0] r_data,
  output logic        r_hit,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [13:0] C_ADDR_TX  = BASE_WADDR + OFS_TXDATA;
  localparam logic [13:0] C_ADDR_ST  = BASE_WADDR + OFS_STATUS;
  localparam logic [13:0] C_ADDR_BD  = BASE_WADDR + OFS_BAUDDIV;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_tx_wr;
  logic          w_st_wr;
  logic          w_bd_wr;
  logic [31:0]   w_status;
  logic          w_unused;

  tx_state_t     r_state;
  logic [7:0]    r_shift;
  logic [15:0]   r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic          r_tx;
  logic [15:0]   r_baud;
  logic          r_ovf;

  assign w_tx_wr  = we && (w_addr == C_ADDR_TX);
  assign w_st_wr  = we && (w_addr == C_ADDR_ST);
  assign w_bd_wr  = we && (w_addr == C_ADDR_BD);
  assign w_push   = w_tx_wr && !w_full;
  assign w_pop    = (r_state == IDLE) && !w_empty;
  assign w_unused = ^w_data[31:16];

  assign uart_tx  = r_tx;
  assign tx_busy  = (r_state != IDLE) || !w_empty;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_data[7:0]),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_comb begin
    w_status                = '0;
    w_status[ST_FULL]       = w_full;
    w_status[ST_EMPTY]      = w_empty;
    w_status[ST_ACTIVE]     = (r_state != IDLE);
    w_status[ST_OVF]        = r_ovf;
    w_status[ST_COUNT +: CW] = w_count;
  end

  // Overflow is judged on the pre-edge full flag, so a same-cycle pop cannot rescue a push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_baud <= DIV_RESET;
      r_ovf  <= 1'b0;
    end else begin
      if (w_bd_wr) begin
        r_baud <= (w_data[15:0] == 16'd0) ? 16'd1 : w_data[15:0];
      end
      if (w_tx_wr && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_st_wr && w_data[ST_OVF]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
      r_hit  <= 1'b0;
    end else if (r_addr == C_ADDR_TX) begin
      r_data <= '0;
      r_hit  <= 1'b1;
    end else if (r_addr == C_ADDR_ST) begin
      r_data <= w_status;
      r_hit  <= 1'b1;
    end else if (r_addr == C_ADDR_BD) begin
      r_data <= {16'd0, r_baud};
      r_hit  <= 1'b1;
    end else begin
      r_data <= '0;
      r_hit  <= 1'b0;
    end
  end

  // Each bit lasts r_baud cycles: the counter is loaded with r_baud-1 and leaves at 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift   <= w_head;
            r_bit_cnt <= r_baud - 16'd1;
            r_tx      <= 1'b0;
            r_state   <= START;
          end
        end
        START: begin
          if (r_bit_cnt == 16'd0) begin
            r_bit_cnt <= r_baud - 16'd1;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (r_bit_cnt == 16'd0) begin
            r_bit_cnt <= r_baud - 16'd1;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (r_bit_cnt == 16'd0) begin
            r_tx    <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter that acts as the responder on the CPU data-memory store/load bus, using the same signal set as the data RAM (we, w_addr, w_data, r_addr, r_data).
- Top-level decodes a small word-address window to this block instead of RAM.
- CPU stores push bytes into an internal FIFO; a bit-serial FSM drives 8N1 frames on uart_tx.
- CPU loads return status and configuration registers with the same 1-cycle read latency as the RAM.

Parameters:
- BASE_WADDR, 14'h3FF0, word index (mem_address[16:3]) of register offset 0; block occupies BASE_WADDR..BASE_WADDR+2.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, >=2.
- DIV_RESET, 434, bit period in clk cycles after reset (50 MHz / 115200).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- we  in  1  store strobe, same cycle as w_addr/w_data.
- w_addr  in  14  store word index.
- w_data  in  32  store data.
- r_addr  in  14  load word index.
- r_data  out  32  registered load data.
- r_hit  out  1  registered: r_data is valid from this block; top-level muxes it over RAM data.
- uart_tx  out  1  serial line, idle high.
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Register map, offset = addr - BASE_WADDR:
  - 0 TXDATA: write only; w_data[7:0] pushed; reads return 0.
  - 1 STATUS:
    - Read bits: [0] full, [1] empty, [2] shifter active, [3] overflow (sticky), [8+:5] FIFO count.
    - Writing a 1 to bit 3 clears overflow; all other bits are read-only.
  - 2 BAUDDIV: R/W, [15:0] bit period in cycles; a written value of 0 is stored as 1; [31:16] read 0.
- Reset (rst==0 at a clk edge): uart_tx=1, tx_busy=0, r_data=0, r_hit=0, FIFO emptied, overflow=0, BAUDDIV=DIV_RESET, FSM=IDLE.
  - Reset mid-frame aborts the frame; the line is high from the next cycle.
- Reads:
  - r_data and r_hit are updated every edge from the r_addr sampled on that edge (1-cycle latency).
  - An unmapped r_addr gives r_data=0 and r_hit=0.
  - Reads have no side effects.
- Push:
  - Condition: we && w_addr==BASE_WADDR && !full, where full is evaluated on the pre-edge count.
  - A push when full is dropped and sets overflow, even if a pop happens the same cycle.
  - Push and pop in the same cycle: the count is unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register, load the bit counter with BAUDDIV-1, and go to START. uart_tx=1 in IDLE.
  - START: uart_tx=0 for BAUDDIV cycles, then DATA.
  - DATA: 8 bits, LSB first, BAUDDIV cycles each, then STOP.
  - STOP: uart_tx=1 for BAUDDIV cycles, then IDLE.
  - Back-to-back frames: IDLE lasts exactly 1 cycle between the stop bit and the next start bit.
- Timing: a TXDATA write at edge N into an empty FIFO with the FSM in IDLE makes uart_tx low from edge N+1. Frame length is 10*BAUDDIV cycles.
- uart_tx is driven from a flop (glitch-free).
- A BAUDDIV write mid-frame takes effect at the next bit-counter reload; the current bit completes with the old period.
- Writes to offsets 0..2 never modify RAM; the top-level gates the RAM we with !window_hit.
- Width rules:
  - The bit counter is 16 bits and counts down to 0.
  - The FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - The count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package uart_mmio_pkg holds:
  - register offsets OFS_TXDATA=0, OFS_STATUS=1, OFS_BAUDDIV=2;
  - STATUS bit positions;
  - the tx_state_t enum {IDLE, START, DATA, STOP}.
- Sub-module uart_tx_fifo: synchronous FIFO, parameterised width 8 and depth, with push/pop/full/empty/count.
  - Reads are show-ahead (head visible combinationally).
  - Shares clk/rst.
- FSM, baud counter and register decode stay in uart_tx_mmio.

Test Plan:
- Reset, then read STATUS -> r_data=32'h0000_0002 one cycle later, r_hit=1, uart_tx=1, tx_busy=0; read BAUDDIV -> 434.
- Write BAUDDIV=4, write TXDATA=0x55 -> uart_tx low 1 edge later. Line then shows 0, 1,0,1,0,1,0,1,0, 1 with 4 cycles per bit (40 cycles total), then tx_busy=0.
- BAUDDIV=4, write 0xA5 and 0x3C back-to-back -> second start bit begins exactly 1 cycle after the first stop bit ends; count reads 1 then 0.
- Stall the FSM with BAUDDIV=16'hFFFF, push 17 bytes -> the first is popped into the shifter and 16 are accepted, so STATUS reads full=1, count=16. The 18th push is dropped and overflow=1. Write STATUS=0x8 -> overflow=0, other fields unchanged.
- Assert rst=0 for one edge in the middle of a DATA bit -> uart_tx=1 the next cycle, FIFO empty, BAUDDIV=434.
- Write BAUDDIV=0 -> reads back 1. Read r_addr=BASE_WADDR+3 -> r_data=0, r_hit=0.
